muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Iterative RV32M multiply/divide unit. It sits beside the ALU in the execute stage of the pipelined core. The core raises `start` for an M-extension instruction and holds the instruction in execute (front-end stalled) until `done`. Operand width (`XLEN`) and bits retired per cycle (`STEP`) are parameters, which trades area against latency.

## Interface
- `XLEN`, default 32: operand and result width; must be even and at least 8.
- `STEP`, default 1: quotient/multiplier bits processed per cycle; must be 1, 2 or 4 and divide `XLEN`. Define N = `XLEN`/`STEP`.
- `clk`  in  1: single clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only when `ready`=1.
- `funct3`  in  3: operation. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, `rs2`  in  `XLEN` each: operands, captured on the accepting edge.
- `kill`  in  1: pipeline flush; aborts any operation.
- `ready`  out  1: can accept `start`.
- `busy`  out  1: operation in flight (core stall request).
- `done`  out  1: one-cycle pulse; `result` valid in the same cycle.
- `result`  out  `XLEN`: registered result; holds until the next `done`.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE→PREP on `start`. Latch `funct3`, `rs1`, `rs2`.
- PREP (1 cycle):
  - Take magnitudes of operands that are signed for the op. MULH: both signed. MULHSU: `rs1` only. DIV/REM: both.
  - Record the result sign. Load the iteration counter with N.
  - Detect the division special cases below; if one is present, preset the result and go to FIX; otherwise go to CALC.
- CALC (N cycles):
  - Multiply: shift-add on a 2·`XLEN` accumulator, `STEP` multiplier bits per cycle.
  - Divide: restoring division, `STEP` quotient bits per cycle; `XLEN`+1-bit partial remainder.
  - Counter decrements each cycle; at 1 the FSM goes to FIX.
- FIX (1 cycle): apply two's-complement sign correction, then select the output.
  - MUL returns the low half of the product. MULH/MULHSU/MULHU return the high half.
  - DIV/DIVU return the quotient. REM/REMU return the remainder.
  - Remainder sign follows `rs1`; quotient sign is sign(`rs1`) XOR sign(`rs2`).
  - Registers `result`, then goes to DONE.
- DONE (1 cycle): `done`=1. Goes to PREP if `start`=1, else IDLE.
- Division special cases (RISC-V defined):
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = `rs1`.
  - Signed overflow (`rs1` = most-negative value, `rs2` = −1, DIV/REM only): quotient = most-negative value; remainder = 0.
- `ready` = (state IDLE or DONE). `busy` = (state PREP, CALC or FIX).
- `kill` at any edge forces IDLE; no `done` follows; `result` is unchanged.
- `kill` and `start` on the same edge: `kill` wins and the request is dropped.
- `start` while `busy`: ignored.

## Timing
- Reset (asynchronous, mid-operation included): state IDLE; `ready`=1, `busy`=0, `done`=0, `result`=0; counter and datapath registers cleared.
- Normal latency: `start` accepted at edge E0 gives `done` high in the cycle after edge E0+N+2.
  - `XLEN`=32, `STEP`=1: 34 cycles.
  - `STEP`=2: 18 cycles.
  - `STEP`=4: 10 cycles.
- Special-case latency: `done` high after edge E0+2, regardless of `STEP`.
- Back-to-back throughput: a `start` in the DONE cycle is accepted, so a new operation begins with no idle cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- MUL 7 × −3 (0xFFFFFFFD), `STEP`=1 → `result` 0xFFFFFFEB; `done` exactly 34 cycles after the start edge; `busy` high for cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). DIVU 100 / 7 → 14. REMU 100 / 7 → 2. Repeat with `STEP`=2 (latency 18) and `STEP`=4 (latency 10); same results.
- Special cases:
  - DIV 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. Both with `done` 2 cycles after start.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Assert `kill` 10 cycles into a DIV → no `done`; `ready`=1 next cycle; `result` keeps its previous value. Then `start` MUL 3 × 4 → 12.
- Back-to-back: new `start` (DIVU 9 / 3) in the DONE cycle of a MUL → second `done` 34 cycles later with `result` 3.
- Reset mid-operation: `resetn` low at cycle 15 of a MUL → all outputs at reset values immediately; no `done` after release.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, STEP bits retired per cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; ready
// PREP  | operand magnitudes, result signs, special-case detection
// CALC  | N iterations of shift-add / restoring-divide
// FIX   | sign correction and result selection; result registered
// DONE  | done pulse; a new start is accepted here
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / STEP;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]   N_CNT   = CW'(N);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              neg_q;
    logic              neg_r;
    logic              special;

    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   spec_val;

    logic [XLEN+STEP-1:0] mul_sum;
    logic [2*XLEN-1:0]    mul_next;
    logic [XLEN-1:0]      div_rem;
    logic [XLEN-1:0]      div_quo;
    logic [XLEN:0]        div_sh;
    logic [XLEN:0]        div_diff;
    logic [2*XLEN-1:0]    div_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_sel;

    // opa/opb hold the raw operands until PREP, magnitudes afterwards
    assign is_div   = op[2];
    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign neg_a    = a_signed && opa[XLEN-1];
    assign neg_b    = b_signed && opb[XLEN-1];
    assign mag_a    = neg_a ? (-opa) : opa;
    assign mag_b    = neg_b ? (-opb) : opb;
    assign div_zero = is_div && (opb == '0);
    assign div_ovf  = is_div && !op[0] && (opa == MOST_NEG) && (opb == '1);

    always_comb begin
        spec_val = '0;
        if (div_zero) begin
            spec_val = op[1] ? opa : '1;
        end else if (!op[1]) begin
            spec_val = MOST_NEG;
        end
    end

    // acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]}
                    + ({{STEP{1'b0}}, opa} * {{XLEN{1'b0}}, acc[STEP-1:0]});
    assign mul_next = {mul_sum, acc[XLEN-1:STEP]};

    // acc = {partial remainder, dividend/quotient shift register}
    always_comb begin
        div_rem  = acc[2*XLEN-1:XLEN];
        div_quo  = acc[XLEN-1:0];
        div_sh   = '0;
        div_diff = '0;
        for (int i = 0; i < STEP; i++) begin
            div_sh   = {div_rem, div_quo[XLEN-1]};
            div_diff = div_sh - {1'b0, opb};
            if (!div_diff[XLEN]) begin
                div_rem = div_diff[XLEN-1:0];
                div_quo = {div_quo[XLEN-2:0], 1'b1};
            end else begin
                div_rem = div_sh[XLEN-1:0];
                div_quo = {div_quo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign div_next = {div_rem, div_quo};

    assign prod_fix = neg_q ? (-acc) : acc;
    assign quo_fix  = neg_q ? (-acc[XLEN-1:0]) : acc[XLEN-1:0];
    assign rem_fix  = neg_r ? (-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

    always_comb begin
        res_sel = prod_fix[2*XLEN-1:XLEN];
        if (special) begin
            res_sel = acc[XLEN-1:0];
        end else if (is_div) begin
            res_sel = op[1] ? rem_fix : quo_fix;
        end else if (op[1:0] == 2'b00) begin
            res_sel = prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            op      <= '0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            result  <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (kill) begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= funct3;
                        opa   <= rs1;
                        opb   <= rs2;
                        state <= S_PREP;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_PREP: begin
                    opa     <= mag_a;
                    opb     <= mag_b;
                    neg_q   <= neg_a ^ neg_b;
                    neg_r   <= neg_a;
                    cnt     <= N_CNT;
                    special <= div_zero || div_ovf;
                    if (div_zero || div_ovf) begin
                        acc   <= {{XLEN{1'b0}}, spec_val};
                        state <= S_FIX;
                    end else begin
                        acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= res_sel;
                    state  <= S_DONE;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    ready  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: three instances (STEP 1, 2, 4) share one
// stimulus bus so every operation is checked at all three latencies.
module tb_muldiv_iter;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;

    logic        ready1, busy1, done1;
    logic        ready2, busy2, done2;
    logic        ready4, busy4, done4;
    logic [31:0] result1, result2, result4;

    int tests;
    int failed;

    muldiv_iter #(.XLEN(32), .STEP(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .kill(kill),
        .ready(ready1), .busy(busy1), .done(done1), .result(result1)
    );

    muldiv_iter #(.XLEN(32), .STEP(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .kill(kill),
        .ready(ready2), .busy(busy2), .done(done2), .result(result2)
    );

    muldiv_iter #(.XLEN(32), .STEP(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .kill(kill),
        .ready(ready4), .busy(busy4), .done(done4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on all three instances; k counts cycles after the accepting edge.
    task automatic run3(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int l1, input int l2, input int l4);
        int k, got1, got2, got4, bc;
        logic [31:0] r1, r2, r4;
        r1 = 'x; r2 = 'x; r4 = 'x;
        got1 = 0; got2 = 0; got4 = 0; bc = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k <= 60 && (got1 == 0 || got2 == 0 || got4 == 0)) begin
            if (done1 && got1 == 0) begin got1 = k; r1 = result1; end
            if (done2 && got2 == 0) begin got2 = k; r2 = result2; end
            if (done4 && got4 == 0) begin got4 = k; r4 = result4; end
            if (k >= 1 && got1 == 0 && busy1) bc++;
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_res_s1"}, r1, exp);
        check({tag, "_res_s2"}, r2, exp);
        check({tag, "_res_s4"}, r4, exp);
        check({tag, "_lat_s1"}, got1, l1);
        check({tag, "_lat_s2"}, got2, l2);
        check({tag, "_lat_s4"}, got4, l4);
        check({tag, "_busy_cycles_s1"}, bc, l1 - 1);
    endtask

    initial begin
        int k, seen1, seen2;
        tests = 0; failed = 0;
        resetn = 1'b0; start = 1'b0; funct3 = 3'b000;
        rs1 = '0; rs2 = '0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready1, 1'b1);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_result", result1, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        run3("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 18, 10);
        run3("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 18, 10);
        run3("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 18, 10);
        run3("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 18, 10);
        run3("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 18, 10);
        run3("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 18, 10);
        run3("divu",   3'b101, 32'd100,      32'd7,        32'd14,       34, 18, 10);
        run3("remu",   3'b111, 32'd100,      32'd7,        32'd2,        34, 18, 10);
        run3("div_z",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2, 2, 2);
        run3("rem_z",  3'b110, 32'd5,        32'd0,        32'd5,        2, 2, 2);

        // kill ten cycles into a DIV: STEP=1 and STEP=2 must never finish it
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; rs1 = 32'hFFFFFFF9; rs2 = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        seen1 = 0; seen2 = 0;
        for (int i = 0; i < 10; i++) begin
            if (done1) seen1++;
            if (done2) seen2++;
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_ready", ready1, 1'b1);
        check("kill_busy", busy1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (done1) seen1++;
            if (done2) seen2++;
            @(posedge clk); #1;
        end
        check("kill_no_done_s1", seen1, 0);
        check("kill_no_done_s2", seen2, 0);
        check("kill_result_kept_s1", result1, 32'd5);
        check("kill_result_kept_s2", result2, 32'd5);

        run3("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 34, 18, 10);
        run3("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 2, 2);
        run3("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 2, 2);

        // back-to-back: second start issued during the DONE cycle of the first
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done1 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_first_lat", k, 34);
        check("b2b_first_res", result1, 32'd30);
        start = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accepted_busy", busy1, 1'b1);
        k = 0;
        while (!done1 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("b2b_second_lat", k, 34);
        check("b2b_second_res", result1, 32'd3);
        repeat (40) @(posedge clk);
        #1;

        // asynchronous reset in the middle of a MUL
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_busy_before_rst", busy1, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", ready1, 1'b1);
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_done", done1, 1'b0);
        check("mid_rst_result", result1, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        seen1 = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done1) seen1++;
        end
        check("mid_rst_no_done", seen1, 0);
        check("mid_rst_result_held", result1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
